// File: rtl/sdram_pkg.sv
// Shared constants and types for the two-client SDRAM arbiter.
package sdram_pkg;

  localparam int DEF_ADDR_W  = 24;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_BURST_W = 10;
  localparam int DEF_TIMEOUT = 1023;

  localparam logic [1:0] SRC_C0_WR = 2'd0;
  localparam logic [1:0] SRC_C0_RD = 2'd1;
  localparam logic [1:0] SRC_C1_WR = 2'd2;
  localparam logic [1:0] SRC_C1_RD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REQ,
    ST_XFER,
    ST_GAP
  } state_t;

  // Even source IDs are writers, odd IDs are readers.
  function automatic logic is_wr_src(input logic [1:0] id);
    return !id[0];
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Round-robin picker: the first active request after the last grant wins,
// with the last grant itself lowest priority.
module sdram_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan farthest-first so the nearest candidate after 'last' is written last.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates two clients (one write and one read port each) onto a single
// SDRAM controller, with per-burst grants and a first-ack timeout.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | controller not initialised, no grant
//   ARB     | round-robin pick, latch addr/burst of the winner
//   REQ     | request driven, waiting for first ack (timeout running)
//   XFER    | request driven, counting remaining acks
//   GAP     | one cycle with both requests low
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sdram_init_done,

  input  logic               c0_wr_req,
  input  logic [ADDR_W-1:0]  c0_wr_addr,
  input  logic [BURST_W-1:0] c0_wr_burst,
  input  logic [DATA_W-1:0]  c0_din,
  output logic               c0_wr_ack,
  input  logic               c0_rd_req,
  input  logic [ADDR_W-1:0]  c0_rd_addr,
  input  logic [BURST_W-1:0] c0_rd_burst,
  output logic               c0_rd_ack,
  output logic [DATA_W-1:0]  c0_dout,

  input  logic               c1_wr_req,
  input  logic [ADDR_W-1:0]  c1_wr_addr,
  input  logic [BURST_W-1:0] c1_wr_burst,
  input  logic [DATA_W-1:0]  c1_din,
  output logic               c1_wr_ack,
  input  logic               c1_rd_req,
  input  logic [ADDR_W-1:0]  c1_rd_addr,
  input  logic [BURST_W-1:0] c1_rd_burst,
  output logic               c1_rd_ack,
  output logic [DATA_W-1:0]  c1_dout,

  output logic               sdram_wr_req,
  output logic [ADDR_W-1:0]  sdram_wr_addr,
  output logic [BURST_W-1:0] sdram_wr_burst,
  output logic [DATA_W-1:0]  sdram_din,
  input  logic               sdram_wr_ack,
  output logic               sdram_rd_req,
  output logic [ADDR_W-1:0]  sdram_rd_addr,
  output logic [BURST_W-1:0] sdram_rd_burst,
  input  logic               sdram_rd_ack,
  input  logic [DATA_W-1:0]  sdram_dout,

  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state, nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] remain;
  logic [TMR_W-1:0]   tmr;

  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [ADDR_W-1:0]  pick_addr;
  logic [BURST_W-1:0] pick_burst;

  logic active, sel_wr, ack_sel, last_word, tmr_done;

  sdram_rr_pick u_pick (
    .req   ({c1_rd_req, c1_wr_req, c0_rd_req, c0_wr_req}),
    .last  (grant_id),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_addr  = c0_wr_addr;
    pick_burst = c0_wr_burst;
    case (pick_idx)
      SRC_C0_WR: begin pick_addr = c0_wr_addr; pick_burst = c0_wr_burst; end
      SRC_C0_RD: begin pick_addr = c0_rd_addr; pick_burst = c0_rd_burst; end
      SRC_C1_WR: begin pick_addr = c1_wr_addr; pick_burst = c1_wr_burst; end
      default:   begin pick_addr = c1_rd_addr; pick_burst = c1_rd_burst; end
    endcase
  end

  assign active    = (state == ST_REQ) || (state == ST_XFER);
  assign sel_wr    = is_wr_src(grant_id);
  assign ack_sel   = active && (sel_wr ? sdram_wr_ack : sdram_rd_ack);
  assign last_word = (remain == BURST_W'(1));
  assign tmr_done  = (tmr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // A single-word burst finishes on its first ack and skips XFER.
  always_comb begin
    nxt = state;
    if (!sdram_init_done) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: nxt = ST_ARB;
        ST_ARB:  if (pick_valid) nxt = ST_REQ;
        ST_REQ: begin
          if (ack_sel)       nxt = last_word ? ST_GAP : ST_XFER;
          else if (tmr_done) nxt = ST_GAP;
        end
        ST_XFER: if (ack_sel && last_word) nxt = ST_GAP;
        ST_GAP:  nxt = ST_ARB;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sdram_wr_req = active && sel_wr;
    sdram_rd_req = active && !sel_wr;
    busy         = (state == ST_REQ) || (state == ST_XFER) || (state == ST_GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id    <= SRC_C1_RD;
      addr_q      <= '0;
      burst_q     <= '0;
      remain      <= '0;
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else if (sdram_init_done) begin
      case (state)
        ST_ARB: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            addr_q   <= pick_addr;
            burst_q  <= pick_burst;
            remain   <= (pick_burst == '0) ? BURST_W'(1) : pick_burst;
            tmr      <= TMR_W'(TIMEOUT - 1);
          end
        end
        ST_REQ: begin
          if (ack_sel)       remain      <= remain - BURST_W'(1);
          else if (tmr_done) timeout_err <= 1'b1;
          else               tmr         <= tmr - TMR_W'(1);
        end
        ST_XFER: if (ack_sel) remain <= remain - BURST_W'(1);
        default: ;
      endcase
    end
  end

  assign sdram_wr_addr  = addr_q;
  assign sdram_rd_addr  = addr_q;
  assign sdram_wr_burst = burst_q;
  assign sdram_rd_burst = burst_q;
  assign sdram_din      = (grant_id == SRC_C1_WR) ? c1_din : c0_din;

  assign c0_wr_ack = active && (grant_id == SRC_C0_WR) && sdram_wr_ack;
  assign c0_rd_ack = active && (grant_id == SRC_C0_RD) && sdram_rd_ack;
  assign c1_wr_ack = active && (grant_id == SRC_C1_WR) && sdram_wr_ack;
  assign c1_rd_ack = active && (grant_id == SRC_C1_RD) && sdram_rd_ack;

  assign c0_dout = sdram_dout;
  assign c1_dout = sdram_dout;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 10;
  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst, init_done;
  logic               c0_wr_req, c0_rd_req, c1_wr_req, c1_rd_req;
  logic [ADDR_W-1:0]  c0_wr_addr, c0_rd_addr, c1_wr_addr, c1_rd_addr;
  logic [BURST_W-1:0] c0_wr_burst, c0_rd_burst, c1_wr_burst, c1_rd_burst;
  logic [DATA_W-1:0]  c0_din, c1_din, c0_dout, c1_dout;
  logic               c0_wr_ack, c0_rd_ack, c1_wr_ack, c1_rd_ack;
  logic               sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
  logic [ADDR_W-1:0]  sdram_wr_addr, sdram_rd_addr;
  logic [BURST_W-1:0] sdram_wr_burst, sdram_rd_burst;
  logic [DATA_W-1:0]  sdram_din, sdram_dout;
  logic [1:0]         grant_id;
  logic               busy, timeout_err;

  int passed = 0;
  int total  = 0;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sdram_init_done(init_done),
    .c0_wr_req(c0_wr_req), .c0_wr_addr(c0_wr_addr), .c0_wr_burst(c0_wr_burst), .c0_din(c0_din),
    .c0_wr_ack(c0_wr_ack), .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_burst(c0_rd_burst),
    .c0_rd_ack(c0_rd_ack), .c0_dout(c0_dout),
    .c1_wr_req(c1_wr_req), .c1_wr_addr(c1_wr_addr), .c1_wr_burst(c1_wr_burst), .c1_din(c1_din),
    .c1_wr_ack(c1_wr_ack), .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_burst(c1_rd_burst),
    .c1_rd_ack(c1_rd_ack), .c1_dout(c1_dout),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
    .sdram_din(sdram_din), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst),
    .sdram_rd_ack(sdram_rd_ack), .sdram_dout(sdram_dout),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (!(sdram_wr_req || sdram_rd_req) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(sdram_wr_req || sdram_rd_req), 1);
  endtask

  int hits, cnt, exp_id;
  int rr_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; init_done = 1'b0;
    c0_wr_req = 0; c0_rd_req = 0; c1_wr_req = 0; c1_rd_req = 0;
    c0_wr_addr = '0; c0_rd_addr = '0; c1_wr_addr = '0; c1_rd_addr = '0;
    c0_wr_burst = '0; c0_rd_burst = '0; c1_wr_burst = '0; c1_rd_burst = '0;
    c0_din = '0; c1_din = '0; sdram_dout = 16'hBEEF;
    sdram_wr_ack = 0; sdram_rd_ack = 0;
    #1;
    chk("rst_grant", grant_id, 3);
    chk("rst_busy", busy, 0);
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("dout_fan0", c0_dout, 16'hBEEF);
    chk("dout_fan1", c1_dout, 16'hBEEF);
    tick(); tick();
    rst = 1'b0;

    // No grant before the controller is initialised.
    c0_wr_req = 1; c0_wr_addr = 24'h000100; c0_wr_burst = 4; c0_din = 16'hA5A5;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sdram_wr_req || sdram_rd_req || busy) hits++;
    end
    chk("no_req_before_init", hits, 0);
    init_done = 1'b1;
    tick(); chk("init_lat_1", sdram_wr_req, 0);
    tick(); chk("init_lat_2", sdram_wr_req, 1);
    chk("w4_grant", grant_id, 0);
    chk("w4_addr", sdram_wr_addr, 24'h000100);
    chk("w4_burst", sdram_wr_burst, 4);
    chk("w4_din", sdram_din, 16'hA5A5);
    chk("w4_busy", busy, 1);

    // Client drops its request; the burst still completes. A stray rd ack is ignored.
    c0_wr_req = 0;
    for (int k = 0; k < 4; k++) begin
      sdram_wr_ack = 1; sdram_rd_ack = (k == 0);
      #1 chk("w4_ack_route", {c1_rd_ack, c1_wr_ack, c0_rd_ack, c0_wr_ack}, 4'b0001);
      tick();
      sdram_wr_ack = 0; sdram_rd_ack = 0;
      chk("w4_req_after_ack", sdram_wr_req, (k < 3) ? 1 : 0);
    end
    chk("w4_gap_busy", busy, 1);
    tick();
    chk("w4_gap_one_cycle", busy, 0);

    // Round robin with all four sources, from reset priority.
    rst = 1'b1;
    c0_wr_req = 1; c0_rd_req = 1; c1_wr_req = 1; c1_rd_req = 1;
    c0_wr_addr = 24'h10; c0_rd_addr = 24'h20; c1_wr_addr = 24'h30; c1_rd_addr = 24'h40;
    c0_wr_burst = 1; c0_rd_burst = 1; c1_wr_burst = 1; c1_rd_burst = 1;
    c0_din = 16'h1111; c1_din = 16'h2222;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 5; s++) begin
      exp_id = rr_seq[s];
      wait_req(8);
      chk("rr_grant", grant_id, exp_id);
      if (exp_id % 2 == 0) begin
        chk("rr_wr_addr", sdram_wr_addr, 32'h10 * (exp_id + 1));
        chk("rr_din", sdram_din, (exp_id == 2) ? 16'h2222 : 16'h1111);
        sdram_wr_ack = 1;
      end else begin
        chk("rr_rd_addr", sdram_rd_addr, 32'h10 * (exp_id + 1));
        sdram_rd_ack = 1;
      end
      #1 chk("rr_ack_route", {c1_rd_ack, c1_wr_ack, c0_rd_ack, c0_wr_ack}, 32'd1 << exp_id);
      tick();
      sdram_wr_ack = 0; sdram_rd_ack = 0;
    end

    // c1_rd never acked: timeout, then c0_wr takes over.
    c0_rd_req = 0; c1_wr_req = 0; c0_wr_burst = 8;
    wait_req(8);
    chk("to_grant", grant_id, 3);
    chk("to_rd_req", sdram_rd_req, 1);
    cnt = 0;
    while (sdram_rd_req && cnt < 1100) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", cnt, TIMEOUT);
    chk("to_err", timeout_err, 1);
    chk("to_gap_busy", busy, 1);
    wait_req(8);
    chk("to_next_grant", grant_id, 0);
    chk("to_next_burst", sdram_wr_burst, 8);
    c0_wr_req = 0; c1_rd_req = 0;

    // init_done falls mid-burst after three acks.
    for (int k = 0; k < 3; k++) begin
      sdram_wr_ack = 1;
      tick();
      sdram_wr_ack = 0;
    end
    chk("fall_req_before", sdram_wr_req, 1);
    init_done = 1'b0;
    tick();
    chk("fall_wr_req", sdram_wr_req, 0);
    chk("fall_rd_req", sdram_rd_req, 0);
    chk("fall_busy", busy, 0);
    chk("fall_state", dut.state, ST_IDLE);
    chk("fall_err_kept", timeout_err, 1);

    // Async reset in the middle of a burst.
    c0_wr_req = 1; init_done = 1'b1;
    tick(); chk("reinit_lat_1", sdram_wr_req, 0);
    tick(); chk("reinit_lat_2", sdram_wr_req, 1);
    c0_wr_req = 0;
    for (int k = 0; k < 2; k++) begin
      sdram_wr_ack = 1;
      tick();
      sdram_wr_ack = 0;
    end
    rst = 1'b1;
    #1;
    chk("arst_wr_req", sdram_wr_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 3);
    chk("arst_err", timeout_err, 0);
    chk("arst_addr", sdram_wr_addr, 0);
    chk("arst_burst", sdram_wr_burst, 0);

    // Burst length 0 behaves as a single word.
    c1_wr_req = 1; c1_wr_burst = 0;
    tick();
    rst = 1'b0;
    wait_req(8);
    chk("b0_grant", grant_id, 2);
    chk("b0_din", sdram_din, 16'h2222);
    sdram_wr_ack = 1;
    #1 chk("b0_ack_route", {c1_rd_ack, c1_wr_ack, c0_rd_ack, c0_wr_ack}, 4'b0100);
    c1_wr_req = 0;
    tick();
    sdram_wr_ack = 0;
    chk("b0_req_drop", sdram_wr_req, 0);
    chk("b0_gap_busy", busy, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 24, SDRAM word address width; DATA_W, default 16, data width; BURST_W, default 10, burst-length width; TIMEOUT, default 1023, maximum cycles from grant to first ack.
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic on rising edge; rst  in  1  asynchronous, active-high reset.
REQ-003 Ports SHALL be: sdram_init_done  in  1  controller initialised.
REQ-004 Ports SHALL be, for N in {0,1}: cN_wr_req  in  1 | cN_wr_addr  in  ADDR_W | cN_wr_burst  in  BURST_W | cN_din  in  DATA_W | cN_wr_ack  out  1 | cN_rd_req  in  1 | cN_rd_addr  in  ADDR_W | cN_rd_burst  in  BURST_W | cN_rd_ack  out  1 | cN_dout  out  DATA_W.
REQ-005 Controller-side ports SHALL be: sdram_wr_req  out  1 | sdram_wr_addr  out  ADDR_W | sdram_wr_burst  out  BURST_W | sdram_din  out  DATA_W | sdram_wr_ack  in  1 (high one cycle per accepted word) | sdram_rd_req  out  1 | sdram_rd_addr  out  ADDR_W | sdram_rd_burst  out  BURST_W | sdram_rd_ack  in  1 (high one cycle per valid word) | sdram_dout  in  DATA_W.
REQ-006 Status ports SHALL be: grant_id  out  2  source of current/last grant {0:c0_wr,1:c0_rd,2:c1_wr,3:c1_rd}; busy  out  1; timeout_err  out  1 (sticky).

Function
REQ-007 FSM states SHALL be IDLE, ARB, REQ, XFER, GAP.
REQ-008 IDLE: no grant while sdram_init_done=0; when 1, next state ARB.
REQ-009 ARB: if any of the four requests is high, select one by round-robin starting after grant_id (order 0,1,2,3, wrap 3->0), register its addr/burst, update grant_id, go REQ; else stay ARB.
REQ-010 REQ: drive the selected sdram_wr_req or sdram_rd_req high with registered addr/burst; on the first matching ack go XFER.
REQ-011 XFER: keep request high; count acks; when count reaches the registered burst value, drop request next cycle and go GAP; burst value 0 SHALL be treated as 1.
REQ-012 GAP: one cycle with both sdram requests low, then ARB.
REQ-013 Acks SHALL be routed combinationally only to the granted client (cN_wr_ack = sdram_wr_ack when granted, else 0); the other three client acks SHALL be 0.
REQ-014 sdram_din SHALL combinationally mux the granted writer's cN_din; sdram_dout SHALL be fanned to c0_dout and c1_dout unchanged.
REQ-015 Client request deassertion mid-burst SHALL NOT abort the transfer; the burst completes as registered.
REQ-016 A new request raised in the same cycle as burst completion SHALL be considered in the next ARB cycle.
REQ-017 A cycle counter SHALL start on entry to REQ; if it reaches TIMEOUT with no ack, drop the request, set timeout_err, go GAP; timeout_err clears only on reset.
REQ-018 If sdram_init_done falls in any state, return to IDLE next cycle, drop both sdram requests, and discard the grant.
REQ-019 Acks of the non-selected direction (e.g. rd_ack during a write) SHALL be ignored.
REQ-020 busy SHALL be high in REQ, XFER and GAP.
REQ-021 Worst-case arbitration latency from request to sdram_*_req SHALL be 2 cycles (ARB+REQ) plus pending transfers of up to 3 other sources.

Reset
REQ-022 On rst high, asynchronously: state=IDLE; sdram_wr_req, sdram_rd_req, busy, timeout_err=0; addr/burst registers=0; counters=0; grant_id=3 (so source 0 has first priority).

Structure
REQ-023 State encoding, source-ID constants (0..3) and default parameter values SHALL live in a shared sdram package.
REQ-024 Round-robin selection SHALL be one sub-module, sdram_rr_pick (4 requests + last grant -> valid + index), purely combinational.

Verification
REQ-025 init_done=0, c0_wr_req=1 for 50 cycles -> no sdram_wr_req; init_done=1 -> sdram_wr_req high 2 cycles later.
REQ-026 c0_wr burst=4 at addr 0x000100 -> sdram_wr_addr=0x000100, 4 acks routed to c0_wr_ack only, request low after 4th ack, one GAP cycle.
REQ-027 All four requests held high, burst=1 -> grants in order 0,1,2,3,0 and each source's ack appears only on its own port.
REQ-028 c1_rd granted, no ack for 1023 cycles -> request drops, timeout_err=1, next source granted.
REQ-029 init_done falls during an 8-word burst after 3 acks -> both sdram requests low next cycle, state IDLE, busy=0.
REQ-030 rst asserted mid-burst asynchronously -> all outputs at REQ-022 values before next clock edge.
